alu_req_scheduler: RTL
======================

# alu_req_scheduler

Shares the single 16-cycle-capable `ALU_DESIGN` instance between `N_REQ` independent requesters. Accepts one operation at a time through per-requester valid/ready handshakes, arbitrates round-robin, and drives the ALU operand/command/control ports. It waits a command-dependent latency, captures the ALU outputs, and returns them tagged with the requester id through a valid/ready response channel. It sits between the requester-side logic and the ALU, replacing direct stimulus on `intf`.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `WIDTH`, 8: operand width; matches ALU `OPA`/`OPB`.
- `CMD_W`, 4: ALU command width.
- `ALU_LAT`, 1: cycles from issue to valid result for non-multiply commands.
- `MUL_LAT`, 2: cycles from issue to valid result for multiply commands (`MODE`=1, `CMD`=9 or 10).

Ports:
- `CLK` in 1: clock; all logic on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `req_valid` in N_REQ: request pending, one bit per requester.
- `req_ready` out N_REQ: one-hot accept pulse.
- `req_opa`, `req_opb` in N_REQ*WIDTH: packed operands; requester i occupies slice i.
- `req_cmd` in N_REQ*CMD_W, `req_mode` in N_REQ, `req_cin` in N_REQ: per-requester command, mode and carry-in.
- `OPA`, `OPB` out WIDTH, `CMD` out CMD_W, `MODE`, `CIN`, `CE` out 1, `INP_VALID` out 2: ALU drive.
- `RES` in 2*WIDTH; `COUT`, `OFLOW`, `G`, `L`, `E`, `ERR` in 1: ALU results.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_id` out clog2(N_REQ), `rsp_res` out 2*WIDTH, `rsp_flags` out 6 (`{ERR,E,L,G,OFLOW,COUT}`): response payload.

## Operation
- The FSM has four states: `IDLE`, `ISSUE`, `WAIT`, `RESP`.
- `IDLE`: if any `req_valid` is set, the arbiter picks a winner `g`.
  - `req_ready[g]` is 1 for exactly this cycle.
  - The winner's operands, cmd, mode, cin and id are latched.
  - The FSM moves to `ISSUE`.
- `ISSUE`, one cycle:
  - `CE`=1 and `INP_VALID`=2'b11; `OPA`/`OPB`/`CMD`/`MODE`/`CIN` come from the latch.
  - Latency counter loads `MUL_LAT` if the latched op is a multiply, else `ALU_LAT`.
  - The FSM moves to `WAIT`.
- `WAIT`:
  - `CE`=0 and `INP_VALID`=2'b00, so the ALU holds its outputs.
  - The counter decrements each cycle. When it reaches 1, `RES` and the flags are captured into the response registers and the FSM moves to `RESP`.
- `RESP`: `rsp_valid`=1 and the payload is stable until `rsp_ready`=1. On that cycle the FSM returns to `IDLE`.
- Round-robin pointer:
  - Updates to `g+1` (mod `N_REQ`) on each grant.
  - The search starts at the pointer.
  - A requester holding `req_valid` is served within `N_REQ` grants.
- Requester contract: it must hold its payload stable while `req_valid`=1 and `req_ready`=0. Deasserting `req_valid` before the grant is legal and withdraws the request.
- Only one operation is in flight at a time. Requests arriving outside `IDLE` wait; `req_ready` stays 0.

## Timing
- Reset values (one cycle of `RST`=1): state `IDLE`, pointer 0, and every output 0.
  - Covers `req_ready`, `CE`, `INP_VALID`, `OPA`, `OPB`, `CMD`, `MODE`, `CIN`, `rsp_valid`, `rsp_id`, `rsp_res` and `rsp_flags`.
- `RST` asserted mid-operation aborts the op. No response is produced; the requester must re-issue.
- Request-to-response latency, with `rsp_ready` tied high: grant cycle (`IDLE`) + 1 (`ISSUE`) + lat (`WAIT`) + 1 (`RESP`).
  - Example: `ALU_LAT`=1 gives a grant at cycle t and `rsp_valid` at t+3.
  - Back-to-back throughput is one op per lat+3 cycles.
- Simultaneous `rsp_ready` handshake and new `req_valid`: the FSM is in `IDLE` the next cycle and grants there; there is no same-cycle bypass.
- `rsp_ready` held low stalls the FSM in `RESP` indefinitely. The ALU stays idle with `CE`=0.

## Configuration
- `ALU_SCHED_PRIO0_EN`:
  - Defined: requester 0 has strict priority and wins whenever `req_valid[0]`=1. The others are round-robin among themselves, and the pointer ignores grants to 0.
  - Undefined: pure round-robin across all requesters.

## Structure
- `alu_pkg` gains:
  - the `sched_state_e` enum;
  - the `alu_flags_t` packed struct;
  - the `CMD_MUL_INC`=9 and `CMD_MUL_SHL`=10 constants;
  - the `is_mul(mode, cmd)` function.
- Sub-module `alu_rr_arbiter` (N-way rotating-priority one-hot grant plus pointer) holds the `ALU_SCHED_PRIO0_EN` logic.

## Test plan
- Single request, requester 2: `OPA`=8'h0F, `OPB`=8'h01, `MODE`=1, `CMD`=0 (ADD). Expect `rsp_id`=2, `rsp_res`=16'h0010, `rsp_valid` 3 cycles after the grant.
- All 4 `req_valid` held, with `rsp_ready`=1. Expect grants in order 0,1,2,3,0 and exactly one `req_ready` bit per grant.
- Multiply, `MODE`=1, `CMD`=9, `OPA`=3, `OPB`=4. Expect `rsp_res`=20 (`(3+1)*(4+1)`) and `rsp_valid` 4 cycles after the grant.
- `rsp_ready`=0 for 10 cycles. Expect `rsp_valid` and the payload stable, `CE`=0, and no `req_ready` pulses; a grant follows one cycle after `rsp_ready`=1.
- `RST` pulsed during `WAIT`. Expect all outputs 0 on the next cycle, no response, and pointer 0 (next grant goes to requester 0).
- With `ALU_SCHED_PRIO0_EN` defined and requesters 0 and 1 continuously valid: requester 0 is granted every time. Without the macro the grants alternate 0,1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU request scheduler: FSM states,
// response flag layout and multiply-command decoding.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_e;

  // Bit order matches rsp_flags = {ERR,E,L,G,OFLOW,COUT}.
  typedef struct packed {
    logic err;
    logic e;
    logic l;
    logic g;
    logic oflow;
    logic cout;
  } alu_flags_t;

  localparam logic [7:0] CMD_MUL_INC = 8'd9;
  localparam logic [7:0] CMD_MUL_SHL = 8'd10;

  function automatic logic is_mul(input logic mode, input logic [7:0] cmd);
    return mode && ((cmd == CMD_MUL_INC) || (cmd == CMD_MUL_SHL));
  endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// Rotating-priority one-hot arbiter with its grant pointer.
// ALU_SCHED_PRIO0_EN: requester 0 gets strict priority; the rest rotate.
module alu_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id
);

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  idx;
  logic [N_REQ-1:0] req_rr;
  logic             found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    req_rr = req;
`ifdef ALU_SCHED_PRIO0_EN
    req_rr[0] = 1'b0;
    if (req[0]) begin
      gnt[0] = 1'b1;
      found  = 1'b1;
    end
`endif
    // Search starts at the pointer and wraps once around all requesters.
    for (int i = 0; i < N_REQ; i++) begin
      idx = ID_W'((int'(ptr_q) + i) % N_REQ);
      if (!found && req_rr[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
`ifdef ALU_SCHED_PRIO0_EN
      if (gnt_id != '0) begin
        ptr_d = (int'(gnt_id) == N_REQ - 1) ? ID_W'(1) : gnt_id + ID_W'(1);
      end
`else
      ptr_d = (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + ID_W'(1);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one ALU between N_REQ requesters: arbitrate, issue, wait, respond.
// ALU_SCHED_PRIO0_EN (in alu_rr_arbiter) gives requester 0 strict priority.
module alu_req_scheduler
  import alu_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int WIDTH   = 8,
  parameter  int CMD_W   = 4,
  parameter  int ALU_LAT = 1,
  parameter  int MUL_LAT = 2,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_opa,
  input  logic [N_REQ*WIDTH-1:0]   req_opb,
  input  logic [N_REQ*CMD_W-1:0]   req_cmd,
  input  logic [N_REQ-1:0]         req_mode,
  input  logic [N_REQ-1:0]         req_cin,
  output logic [WIDTH-1:0]         OPA,
  output logic [WIDTH-1:0]         OPB,
  output logic [CMD_W-1:0]         CMD,
  output logic                     MODE,
  output logic                     CIN,
  output logic                     CE,
  output logic [1:0]               INP_VALID,
  input  logic [2*WIDTH-1:0]       RES,
  input  logic                     COUT,
  input  logic                     OFLOW,
  input  logic                     G,
  input  logic                     L,
  input  logic                     E,
  input  logic                     ERR,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]       rsp_res,
  output logic [5:0]               rsp_flags
);

  localparam int CNT_W = 8;

  sched_state_e       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic               mode_q, mode_d, cin_q, cin_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  alu_flags_t         flags_q, flags_d;
  logic [5:0]         flags_vec;

  logic [N_REQ-1:0]   gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               grant_fire;

  assign grant_fire = (state_q == IDLE) && (|req_valid) && !RST;

  alu_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .clk     (CLK),
    .rst     (RST),
    .req     (req_valid),
    .advance (grant_fire),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    cmd_d     = cmd_q;
    mode_d    = mode_q;
    cin_d     = cin_q;
    id_d      = id_q;
    res_d     = res_q;
    flags_d   = flags_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready = gnt;
          id_d      = gnt_id;
          for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
              opa_d  = req_opa[i*WIDTH +: WIDTH];
              opb_d  = req_opb[i*WIDTH +: WIDTH];
              cmd_d  = req_cmd[i*CMD_W +: CMD_W];
              mode_d = req_mode[i];
              cin_d  = req_cin[i];
            end
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = is_mul(mode_q, 8'(cmd_q)) ? CNT_W'(MUL_LAT) : CNT_W'(ALU_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        // ALU is held with CE=0, so its outputs are stable when sampled here.
        if (cnt_q <= CNT_W'(1)) begin
          res_d   = RES;
          flags_d = '{err: ERR, e: E, l: L, g: G, oflow: OFLOW, cout: COUT};
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (RST) req_ready = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    opa_q   <= opa_d;
    opb_q   <= opb_d;
    cmd_q   <= cmd_d;
    mode_q  <= mode_d;
    cin_q   <= cin_d;
    id_q    <= id_d;
    res_q   <= res_d;
    flags_q <= flags_d;
  end

  // Outputs are gated by state so everything reads 0 outside its phase.
  assign flags_vec = flags_q;
  assign CE        = (state_q == ISSUE);
  assign INP_VALID = (state_q == ISSUE) ? 2'b11 : 2'b00;
  assign OPA       = (state_q == ISSUE) ? opa_q : '0;
  assign OPB       = (state_q == ISSUE) ? opb_q : '0;
  assign CMD       = (state_q == ISSUE) ? cmd_q : '0;
  assign MODE      = (state_q == ISSUE) && mode_q;
  assign CIN       = (state_q == ISSUE) && cin_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = (state_q == RESP) ? id_q : '0;
  assign rsp_res   = (state_q == RESP) ? res_q : '0;
  assign rsp_flags = (state_q == RESP) ? flags_vec : 6'b0;

endmodule
